// File: rtl/stage_if.sv
`default_nettype none
// ============================================================================
// stage_if : instruction fetch stage with output slot, skid slot and squash.
// Revision : 1.0
// ============================================================================
module stage_if #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        redirect_in,
    input  logic [15:0] redirect_pc_in,
    input  logic        imem_resp,
    input  logic [15:0] imem_rdata,
    output logic        imem_read,
    output logic [15:0] imem_address,
    output logic [15:0] ir_out,
    output logic [15:0] pc_out,
    output logic        valid_out
);

    localparam logic [1:0] FETCH  = 2'd0;
    localparam logic [1:0] HOLD   = 2'd1;
    localparam logic [1:0] SQUASH = 2'd2;

    localparam logic [15:0] RESET_ADDR = RESET_PC & 16'hFFFE;

    logic [1:0]  state;
    logic [1:0]  next_state;
    logic [15:0] pc;
    logic [15:0] fetch_addr;
    logic [15:0] skid_ir;
    logic [15:0] skid_pc;
    logic        skid_valid;

    logic        consume;
    logic        blocked;
    logic [15:0] redirect_target;
    logic [15:0] fetch_next;

    assign consume         = valid_out & ~stall_in;
    assign blocked         = valid_out & stall_in;
    assign redirect_target = redirect_pc_in & 16'hFFFE;
    assign fetch_next      = fetch_addr + 16'd2;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH: begin
                if (redirect_in) begin
                    next_state = imem_resp ? FETCH : SQUASH;
                end else if (imem_resp && blocked) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (redirect_in || consume) begin
                    next_state = FETCH;
                end
            end
            SQUASH: begin
                if (imem_resp) begin
                    next_state = FETCH;
                end
            end
            default: next_state = FETCH;
        endcase
    end

    always_comb begin
        imem_read    = ~reset & ((state == FETCH) | (state == SQUASH));
        imem_address = fetch_addr;
    end

    // A redirect always empties both slots; the outstanding read is only
    // dropped here if it completes now, otherwise SQUASH waits it out.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_ADDR;
            fetch_addr <= RESET_ADDR;
            ir_out     <= 16'h0000;
            pc_out     <= 16'h0000;
            valid_out  <= 1'b0;
            skid_ir    <= 16'h0000;
            skid_pc    <= 16'h0000;
            skid_valid <= 1'b0;
        end else if (redirect_in) begin
            valid_out  <= 1'b0;
            skid_valid <= 1'b0;
            pc         <= redirect_target;
            if ((state == HOLD) || imem_resp) begin
                fetch_addr <= redirect_target;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (imem_resp) begin
                        pc <= fetch_next;
                        if (!blocked) begin
                            ir_out     <= imem_rdata;
                            pc_out     <= fetch_next;
                            valid_out  <= 1'b1;
                            fetch_addr <= fetch_next;
                        end else begin
                            skid_ir    <= imem_rdata;
                            skid_pc    <= fetch_next;
                            skid_valid <= 1'b1;
                        end
                    end else if (consume) begin
                        valid_out <= 1'b0;
                    end
                end
                HOLD: begin
                    if (consume) begin
                        ir_out     <= skid_ir;
                        pc_out     <= skid_pc;
                        valid_out  <= skid_valid;
                        skid_valid <= 1'b0;
                        fetch_addr <= pc;
                    end
                end
                SQUASH: begin
                    if (imem_resp) begin
                        fetch_addr <= pc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stage_if.sv
`default_nettype none
// tb_stage_if : directed and random checks of the fetch stage against an
// instruction-stream model (sequential pcs, memory contents by address).
module tb_stage_if;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_in;
    logic        redirect_in;
    logic [15:0] redirect_pc_in;
    logic        imem_resp;
    logic [15:0] imem_rdata;
    logic        imem_read;
    logic [15:0] imem_address;
    logic [15:0] ir_out;
    logic [15:0] pc_out;
    logic        valid_out;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_pc;

    always #5 clk = ~clk;

    stage_if #(.RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall_in      (stall_in),
        .redirect_in   (redirect_in),
        .redirect_pc_in(redirect_pc_in),
        .imem_resp     (imem_resp),
        .imem_rdata    (imem_rdata),
        .imem_read     (imem_read),
        .imem_address  (imem_address),
        .ir_out        (ir_out),
        .pc_out        (pc_out),
        .valid_out     (valid_out)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0100: return 16'h1234;
            16'h0102: return 16'h5678;
            default:  return {a[7:0], a[15:8]} ^ 16'hC35A;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, let memory answer if ready, check the
    // visible instruction against the stream model, then check after the edge.
    task automatic cyc(input logic rst, input logic stall, input logic redir,
                       input logic [15:0] tgt, input logic mem_rdy);
        logic        pv, pread, presp;
        logic [15:0] pir, ppc, paddr;
        reset          = rst;
        stall_in       = stall;
        redirect_in    = redir;
        redirect_pc_in = tgt;
        #1;
        imem_resp  = mem_rdy & imem_read;
        imem_rdata = imem_resp ? mem_word(imem_address) : 16'($urandom);
        #1;
        pv = valid_out; pir = ir_out; ppc = pc_out;
        pread = imem_read; paddr = imem_address; presp = imem_resp;
        if (rst) chk("read_in_reset", {15'd0, imem_read}, 16'd0);
        if (pv) begin
            chk("stream_pc", ppc, exp_pc);
            chk("stream_ir", pir, mem_word(ppc - 16'd2));
        end
        if (rst)            exp_pc = 16'h0002;
        else if (redir)     exp_pc = (tgt & 16'hFFFE) + 16'd2;
        else if (pv && !stall) exp_pc = exp_pc + 16'd2;
        @(posedge clk);
        #1;
        if (rst || redir) chk("valid_after_flush", {15'd0, valid_out}, 16'd0);
        if (rst) begin
            chk("addr_after_reset", imem_address, 16'h0000);
            chk("ir_after_reset", ir_out, 16'h0000);
            chk("pc_after_reset", pc_out, 16'h0000);
        end else if (!redir && pv && stall) begin
            chk("stall_valid", {15'd0, valid_out}, 16'd1);
            chk("stall_ir", ir_out, pir);
            chk("stall_pc", pc_out, ppc);
        end
        if (!rst && pread && !presp) begin
            chk("pending_read", {15'd0, imem_read}, 16'd1);
            chk("pending_addr", imem_address, paddr);
        end
    endtask

    initial begin
        reset = 1'b1; stall_in = 1'b0; redirect_in = 1'b0;
        redirect_pc_in = 16'h0000; imem_resp = 1'b0; imem_rdata = 16'h0000;
        exp_pc = 16'h0002;

        // reset state
        cyc(1, 0, 0, 16'h0, 1);
        cyc(1, 0, 0, 16'h0, 1);
        chk("rst_valid", {15'd0, valid_out}, 16'd0);
        chk("rst_read", {15'd0, imem_read}, 16'd0);

        // zero-wait memory, no stall: one instruction per cycle
        cyc(0, 0, 0, 16'h0, 1);
        chk("seq_valid1", {15'd0, valid_out}, 16'd1);
        chk("seq_pc1", pc_out, 16'h0002);
        chk("seq_addr1", imem_address, 16'h0002);
        cyc(0, 0, 0, 16'h0, 1);
        chk("seq_pc2", pc_out, 16'h0004);
        chk("seq_addr2", imem_address, 16'h0004);
        cyc(0, 0, 0, 16'h0, 1);
        chk("seq_pc3", pc_out, 16'h0006);
        chk("seq_valid3", {15'd0, valid_out}, 16'd1);

        // stall with a second response arriving: skid then release
        cyc(0, 0, 1, 16'h0100, 1);
        chk("redir_addr", imem_address, 16'h0100);
        cyc(0, 1, 0, 16'h0, 1);
        chk("hold_ir_a", ir_out, 16'h1234);
        cyc(0, 1, 0, 16'h0, 1);
        chk("hold_read", {15'd0, imem_read}, 16'd0);
        chk("hold_ir_b", ir_out, 16'h1234);
        cyc(0, 1, 0, 16'h0, 1);
        chk("hold_ir_c", ir_out, 16'h1234);
        chk("hold_read2", {15'd0, imem_read}, 16'd0);
        cyc(0, 0, 0, 16'h0, 1);
        chk("skid_ir", ir_out, 16'h5678);
        chk("skid_pc", pc_out, 16'h0104);
        chk("skid_addr", imem_address, 16'h0104);
        chk("skid_read", {15'd0, imem_read}, 16'd1);
        cyc(0, 0, 0, 16'h0, 1);
        chk("after_skid_pc", pc_out, 16'h0106);

        // redirect while a slow read at 0x0010 is pending
        cyc(0, 0, 1, 16'h0010, 1);
        cyc(0, 0, 0, 16'h0, 0);
        cyc(0, 0, 1, 16'h3001, 0);
        chk("squash_addr", imem_address, 16'h0010);
        cyc(0, 0, 0, 16'h0, 0);
        cyc(0, 0, 0, 16'h0, 1);
        chk("squash_valid", {15'd0, valid_out}, 16'd0);
        chk("squash_next_addr", imem_address, 16'h3000);
        cyc(0, 0, 0, 16'h0, 1);
        chk("target_pc", pc_out, 16'h3002);
        chk("target_valid", {15'd0, valid_out}, 16'd1);

        // redirect coincident with response while stalled
        cyc(0, 1, 1, 16'h4000, 1);
        chk("coinc_valid", {15'd0, valid_out}, 16'd0);
        chk("coinc_addr", imem_address, 16'h4000);

        // address wrap at 0xFFFE
        cyc(0, 0, 1, 16'hFFFE, 1);
        cyc(0, 0, 0, 16'h0, 1);
        chk("wrap_pc", pc_out, 16'h0000);
        chk("wrap_addr", imem_address, 16'h0000);

        // reset mid-fetch (overriding redirect and stall), then in HOLD
        cyc(0, 0, 0, 16'h0, 0);
        cyc(1, 1, 1, 16'h1234, 1);
        chk("rst_mid_read", {15'd0, imem_read}, 16'd0);
        cyc(0, 1, 0, 16'h0, 1);
        cyc(0, 1, 0, 16'h0, 1);
        chk("pre_rst_hold_read", {15'd0, imem_read}, 16'd0);
        cyc(1, 0, 0, 16'h0, 1);
        chk("rst_hold_valid", {15'd0, valid_out}, 16'd0);
        cyc(0, 0, 0, 16'h0, 1);
        chk("post_rst_pc", pc_out, 16'h0002);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic        r_rst, r_stall, r_redir, r_rdy;
            logic [15:0] r_tgt;
            r_rst   = ($urandom_range(0, 99) == 0);
            r_stall = ($urandom_range(0, 2) == 0);
            r_redir = ($urandom_range(0, 11) == 0);
            r_rdy   = ($urandom_range(0, 1) == 0);
            r_tgt   = ($urandom_range(0, 7) == 0) ? 16'hFFFD : 16'($urandom);
            cyc(r_rst, r_stall, r_redir, r_tgt, r_rdy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
